// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multicycle controller and its opcode decoder
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_R_EX   = 4'd2,
    S_R_WB   = 4'd3,
    S_BR     = 4'd4,
    S_I_EX   = 4'd5,
    S_I_WB   = 4'd6,
    S_ADDR   = 4'd7,
    S_LD_MEM = 4'd8,
    S_LD_WB  = 4'd9,
    S_ST_MEM = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd15
  } state_e;

  localparam logic [5:0] OP_NOP = 6'b000000;
  localparam logic [5:0] OP_JMP = 6'b000001;
  localparam logic [5:0] OP_BEQ = 6'b100000;
  localparam logic [5:0] OP_BNE = 6'b100001;
  localparam logic [5:0] OP_LI  = 6'b111001;
  localparam logic [5:0] OP_LWI = 6'b111011;
  localparam logic [5:0] OP_SWI = 6'b111100;

  // Prefix classes: R-type is 01xxxx, I-type is 110xxx
  localparam logic [5:0] R_MASK  = 6'b110000;
  localparam logic [5:0] R_MATCH = 6'b010000;
  localparam logic [5:0] I_MASK  = 6'b111000;
  localparam logic [5:0] I_MATCH = 6'b110000;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_FUNC_I = 4'b0010;
  localparam logic [3:0] ALU_PASSB  = 4'b0011;
  localparam logic [3:0] ALU_FUNC_R = 4'b1000;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/ctrl_opcode_decode.sv
// rtl/ctrl_opcode_decode.sv - combinational opcode to post-DECODE state mapping
// Priority order matters: NOP is checked before the prefix classes, LI before I-type.
module ctrl_opcode_decode
  import ctrl_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic [5:0] opcode_i,
  output state_e     next_state_o,
  output logic       branch_ne_o,
  output logic       is_li_o
);

  always_comb begin
    next_state_o = S_FETCH;
    branch_ne_o  = 1'b0;
    is_li_o      = 1'b0;
    if (opcode_i == OP_NOP) begin
      next_state_o = S_FETCH;
    end else if ((opcode_i & R_MASK) == R_MATCH) begin
      next_state_o = S_R_EX;
    end else if (opcode_i == OP_BEQ) begin
      next_state_o = S_BR;
    end else if (opcode_i == OP_BNE) begin
      next_state_o = S_BR;
      branch_ne_o  = 1'b1;
    end else if (opcode_i == OP_LI) begin
      next_state_o = S_I_EX;
      is_li_o      = 1'b1;
    end else if ((opcode_i & I_MASK) == I_MATCH) begin
      next_state_o = S_I_EX;
    end else if (opcode_i == OP_LWI || opcode_i == OP_SWI) begin
      next_state_o = S_ADDR;
    end else if (opcode_i == OP_JMP) begin
      next_state_o = S_JUMP;
    end else if (TRAP_ON_ILLEGAL) begin
      next_state_o = S_TRAP;
    end else begin
      next_state_o = S_FETCH;
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multicycle CPU control FSM with memory handshake and retire counter
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W         = 4,
  parameter int CNT_W           = 32,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write_cond,
  output logic               pc_write,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               ir_write,
  output logic               branch_ne,
  output logic               alu_src_a,
  output logic               reg_write,
  output logic               reg_dst,
  output logic [1:0]         pc_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         alu_src_b,
  output logic               trap,
  output logic [3:0]         state_dbg,
  output logic [CNT_W-1:0]   retired
);

  state_e             state_q, state_d;
  logic               bne_q, bne_d;
  logic               li_q, li_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic [3:0]         alu_op_sel;

  state_e dec_next;
  logic   dec_bne;
  logic   dec_li;

  ctrl_opcode_decode #(
    .TRAP_ON_ILLEGAL(TRAP_ON_ILLEGAL)
  ) u_decode (
    .opcode_i    (opcode),
    .next_state_o(dec_next),
    .branch_ne_o (dec_bne),
    .is_li_o     (dec_li)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_FETCH;
      bne_q     <= 1'b0;
      li_q      <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      bne_q     <= bne_d;
      li_q      <= li_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bne_d         = bne_q;
    li_d          = li_q;
    pc_write_cond = 1'b0;
    pc_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    ir_write      = 1'b0;
    branch_ne     = 1'b0;
    alu_src_a     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    trap          = 1'b0;
    pc_src        = PC_SRC_ALU;
    alu_src_b     = SRCB_RT;
    alu_op_sel    = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        state_d   = dec_next;
        bne_d     = dec_bne;
        li_d      = dec_li;
      end
      S_R_EX: begin
        alu_src_a  = 1'b1;
        alu_op_sel = ALU_FUNC_R;
        state_d    = S_R_WB;
      end
      S_R_WB: begin
        alu_src_a  = 1'b1;
        alu_op_sel = ALU_FUNC_R;
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        state_d    = S_FETCH;
      end
      S_BR: begin
        pc_write_cond = 1'b1;
        alu_src_a     = 1'b1;
        alu_op_sel    = ALU_SUB;
        pc_src        = PC_SRC_ALUOUT;
        branch_ne     = bne_q;
        state_d       = S_FETCH;
      end
      S_I_EX, S_I_WB: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_op_sel = li_q ? ALU_PASSB : ALU_FUNC_I;
        if (state_q == S_I_WB) begin
          reg_write = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d   = S_I_WB;
        end
      end
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        if (opcode == OP_SWI) state_d = S_ST_MEM;
        else                  state_d = S_LD_MEM;
      end
      S_LD_MEM: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = S_LD_WB;
      end
      S_LD_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_ST_MEM: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_SRC_JUMP;
        state_d  = S_FETCH;
      end
      S_TRAP: begin
        trap    = 1'b1;
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase

    // An instruction retires whenever control re-enters FETCH
    retired_d = retired_q;
    if (state_d == S_FETCH && state_q != S_FETCH) retired_d = retired_q + CNT_W'(1);
  end

  assign alu_op    = ALUOP_W'(alu_op_sel);
  assign state_dbg = state_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - scoreboard bench for multicycle_ctrl_fsm
// Instance A: defaults (trap on illegal). Instance B: illegal-as-NOP, 3-bit counter, 5-bit alu_op.
module tb_multicycle_ctrl_fsm;

  typedef struct packed {
    logic [3:0]  st;
    logic [20:0] ctl;
    logic [31:0] ret;
  } rec_t;

  logic       clock;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;

  logic pwc_a, pw_a, iod_a, mrd_a, mwr_a, m2r_a, irw_a, bne_a, sa_a, rw_a, rd_a, trap_a;
  logic [1:0] pcs_a, sb_a;
  logic [3:0] aop_a, st_a;
  logic [31:0] ret_a;

  logic pwc_b, pw_b, iod_b, mrd_b, mwr_b, m2r_b, irw_b, bne_b, sa_b, rw_b, rd_b, trap_b;
  logic [1:0] pcs_b, sb_b;
  logic [4:0] aop_b;
  logic [3:0] st_b;
  logic [2:0] ret_b;

  multicycle_ctrl_fsm dut_a (
    .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write_cond(pwc_a), .pc_write(pw_a), .i_or_d(iod_a), .mem_read(mrd_a),
    .mem_write(mwr_a), .mem_to_reg(m2r_a), .ir_write(irw_a), .branch_ne(bne_a),
    .alu_src_a(sa_a), .reg_write(rw_a), .reg_dst(rd_a), .pc_src(pcs_a),
    .alu_op(aop_a), .alu_src_b(sb_a), .trap(trap_a), .state_dbg(st_a), .retired(ret_a)
  );

  multicycle_ctrl_fsm #(.ALUOP_W(5), .CNT_W(3), .TRAP_ON_ILLEGAL(1'b0)) dut_b (
    .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write_cond(pwc_b), .pc_write(pw_b), .i_or_d(iod_b), .mem_read(mrd_b),
    .mem_write(mwr_b), .mem_to_reg(m2r_b), .ir_write(irw_b), .branch_ne(bne_b),
    .alu_src_a(sa_b), .reg_write(rw_b), .reg_dst(rd_b), .pc_src(pcs_b),
    .alu_op(aop_b), .alu_src_b(sb_b), .trap(trap_b), .state_dbg(st_b), .retired(ret_b)
  );

  wire [20:0] ctl_a = {1'b0, pwc_a, pw_a, iod_a, mrd_a, mwr_a, m2r_a, irw_a, bne_a,
                       sa_a, rw_a, rd_a, pcs_a, aop_a, sb_a, trap_a};
  wire [20:0] ctl_b = {aop_b[4], pwc_b, pw_b, iod_b, mrd_b, mwr_b, m2r_b, irw_b, bne_b,
                       sa_b, rw_b, rd_b, pcs_b, aop_b[3:0], sb_b, trap_b};

  rec_t        q_a[$];
  rec_t        q_b[$];
  rec_t        mon_r;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] ret_m[2];
  logic        cur_bne, cur_li;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected control word for one cycle, straight from the per-state output table
  function automatic logic [20:0] exp_ctl(int st, bit mr, bit bne, bit li);
    logic pwc = 0, pw = 0, iod = 0, mrd = 0, mwr = 0, m2r = 0, irw = 0, bn = 0;
    logic sa = 0, rw = 0, rd = 0, trp = 0;
    logic [1:0] pcs = 2'b00, sb = 2'b00;
    logic [3:0] aop = 4'b0000;
    case (st)
      0:  begin mrd = 1; sb = 2'b01; pw = mr; irw = mr; end
      1:  sb = 2'b11;
      2:  begin sa = 1; aop = 4'b1000; end
      3:  begin sa = 1; aop = 4'b1000; rw = 1; rd = 1; end
      4:  begin pwc = 1; sa = 1; aop = 4'b0001; pcs = 2'b01; bn = bne; end
      5:  begin sa = 1; sb = 2'b10; aop = li ? 4'b0011 : 4'b0010; end
      6:  begin sa = 1; sb = 2'b10; aop = li ? 4'b0011 : 4'b0010; rw = 1; end
      7:  begin sa = 1; sb = 2'b10; end
      8:  begin iod = 1; mrd = 1; end
      9:  begin m2r = 1; rw = 1; end
      10: begin iod = 1; mwr = 1; end
      11: begin pw = 1; pcs = 2'b10; end
      default: trp = 1;
    endcase
    return {1'b0, pwc, pw, iod, mrd, mwr, m2r, irw, bn, sa, rw, rd, pcs, aop, sb, trp};
  endfunction

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic check(string nm, rec_t e, logic [3:0] st, logic [20:0] ctl, logic [31:0] ret);
    checks++;
    if (st !== e.st) begin
      errors++;
      $display("FAIL %s state_dbg: got %0d expected %0d", nm, st, e.st);
    end
    checks++;
    if (ctl !== e.ctl) begin
      errors++;
      $display("FAIL %s controls (state %0d): got %b expected %b", nm, e.st, ctl, e.ctl);
    end
    checks++;
    if (ret !== e.ret) begin
      errors++;
      $display("FAIL %s retired (state %0d): got %0d expected %0d", nm, e.st, ret, e.ret);
    end
  endtask

  always @(negedge clock) begin
    if (q_a.size() > 0) begin
      mon_r = q_a.pop_front();
      check("A", mon_r, st_a, ctl_a, ret_a);
    end
    if (q_b.size() > 0) begin
      mon_r = q_b.pop_front();
      check("B", mon_r, st_b, ctl_b, 32'(ret_b));
    end
  end

  task automatic step(int d, int st, bit mr, logic [5:0] op, bit rst);
    rec_t r;
    mem_ready = mr;
    opcode    = op;
    reset     = rst;
    r.st  = 4'(st);
    r.ctl = exp_ctl(st, mr, cur_bne, cur_li);
    r.ret = ret_m[d];
    if (d == 0) q_a.push_back(r);
    else        q_b.push_back(r);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    mem_ready = rb();
    opcode    = 6'($urandom);
    @(posedge clock);
    #1;
    reset    = 1'b0;
    ret_m[0] = 0;
    ret_m[1] = 0;
  endtask

  // One instruction through the reference model; mw < 0 picks random memory waits
  task automatic run_instr(int d, logic [5:0] op, int mw);
    int fw = $urandom_range(0, 2);
    int w;
    int ms;
    bit trapped = 0;
    for (int i = 0; i < fw; i++) step(d, 0, 0, 6'($urandom), 0);
    step(d, 0, 1, 6'($urandom), 0);
    step(d, 1, rb(), op, 0);
    if (op == 6'b000000) begin
    end else if (op[5:4] == 2'b01) begin
      step(d, 2, rb(), op, 0);
      step(d, 3, rb(), op, 0);
    end else if (op == 6'b100000 || op == 6'b100001) begin
      cur_bne = op[0];
      step(d, 4, rb(), op, 0);
    end else if (op == 6'b111001 || op[5:3] == 3'b110) begin
      cur_li = (op == 6'b111001);
      step(d, 5, rb(), op, 0);
      step(d, 6, rb(), op, 0);
    end else if (op == 6'b111011 || op == 6'b111100) begin
      step(d, 7, rb(), op, 0);
      w  = (mw < 0) ? int'($urandom_range(0, 2)) : mw;
      ms = (op == 6'b111011) ? 8 : 10;
      for (int i = 0; i < w; i++) step(d, ms, 0, op, 0);
      step(d, ms, 1, op, 0);
      if (op == 6'b111011) step(d, 9, rb(), op, 0);
    end else if (op == 6'b000001) begin
      step(d, 11, rb(), op, 0);
    end else if (d == 0) begin
      for (int i = 0; i < 10; i++) step(d, 15, rb(), op, 0);
      do_reset();
      trapped = 1;
    end
    if (!trapped) ret_m[d] = (d == 0) ? ret_m[d] + 1 : ((ret_m[d] + 1) & 32'h7);
  endtask

  function automatic logic [5:0] pick();
    case ($urandom_range(0, 9))
      0: return 6'b000000;
      1: return 6'b000001;
      2: return 6'b100000;
      3: return 6'b100001;
      4: return 6'b111001;
      5: return 6'b111011;
      6: return 6'b111100;
      7: return {2'b01, 4'($urandom)};
      8: return {3'b110, 3'($urandom)};
      default: return 6'($urandom);
    endcase
  endfunction

  initial begin
    reset     = 1'b1;
    opcode    = 6'b0;
    mem_ready = 1'b0;
    cur_bne   = 1'b0;
    cur_li    = 1'b0;
    ret_m[0]  = 0;
    ret_m[1]  = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    run_instr(0, 6'b010000, 0);
    run_instr(0, 6'b100001, 0);
    run_instr(0, 6'b111011, 2);
    run_instr(0, 6'b111001, 0);
    run_instr(0, 6'b110101, 0);
    run_instr(0, 6'b100000, 0);
    run_instr(0, 6'b000000, 0);
    run_instr(0, 6'b000001, 0);
    run_instr(0, 6'b111100, 1);

    // Reset while a store waits on memory
    step(0, 0, 1, 6'($urandom), 0);
    step(0, 1, rb(), 6'b111100, 0);
    step(0, 7, rb(), 6'b111100, 0);
    step(0, 10, 0, 6'b111100, 0);
    step(0, 10, 0, 6'b111100, 1);
    ret_m[0] = 0;
    ret_m[1] = 0;
    run_instr(0, 6'b010011, 0);

    run_instr(0, 6'b111111, 0);
    run_instr(0, 6'b100001, 0);
    for (int i = 0; i < 150; i++) run_instr(0, pick(), -1);

    do_reset();
    for (int i = 0; i < 9; i++) run_instr(1, 6'b000001, 0);
    run_instr(1, 6'b111111, 0);
    for (int i = 0; i < 100; i++) run_instr(1, pick(), -1);
    step(1, 0, 0, 6'($urandom), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
